enigma_step_controller: RTL and testbench
=========================================

# enigma_step_controller

Sequencer between the keyboard/settings front end and the Enigma rotor stepping datapath and cipher path. It accepts rotor settings and keystrokes over valid/ready handshakes. For each settings load it drives a load pulse into the rotor datapath. For each keystroke it generates the rotor-advance pulse, waits for the knock carries to settle, launches one encryption and returns the ciphertext letter over an output handshake.

## Interface
Parameters:
- ROTATE_HOLD, 2: cycles `rotate` is held high per keystroke; legal range 1–15.
- SETTLE_CYCLES, 3: cycles after `rotate` falls before `enc_start`; minimum 2, which covers the registered knock carry through two rotors; legal range 2–15.

Ports (one clock; reset is synchronous and active-low):
- clock  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  synchronous active-low reset.
- settings_valid  in  1  new settings offered.
- settings_ready  out  1  controller can take settings.
- set_type_3/2/1  in  3 each  rotor types; legal values 0–4.
- set_start_3/2/1  in  5 each  rotor start positions; legal values 0–25.
- key_valid  in  1  keystroke offered.
- key_ready  out  1  controller can take a keystroke.
- key_code  in  5  plaintext letter; legal values 0–25.
- rotate  out  1  advance request to the rotor datapath, which is rising-edge detected there.
- rotor_load  out  1  one-cycle load pulse to the rotor datapath.
- rotor_type_3/2/1  out  3 each  registered active types.
- rotor_start_3/2/1  out  5 each  registered start positions.
- enc_start  out  1  one-cycle encryption launch.
- enc_key  out  5  letter presented with `enc_start`; held stable until `enc_done`.
- enc_done  in  1  cipher path result valid.
- enc_char  in  5  ciphertext letter.
- out_valid  out  1  ciphertext available.
- out_char  out  5  ciphertext letter.
- out_ready  in  1  consumer accepts the ciphertext.
- bad_key  out  1  one-cycle pulse when a keystroke with `key_code` > 25 is accepted.
- cfg_error  out  1  sticky flag set by a rejected settings load.

## Operation
States: IDLE, LOAD, STEP, SETTLE, ENC, WAIT_ENC, OUT.
- IDLE:
  - `settings_ready` = `key_ready` = 1.
  - `settings_valid` has priority over `key_valid`. If both are asserted in the same cycle, settings are accepted and `key_ready` is 0 in that cycle.
- Settings accept:
  - Any type > 4 or any start > 25 is a reject. Set `cfg_error`, keep the old configuration, stay in IDLE.
  - Otherwise latch all six fields, clear `cfg_error`, go to LOAD.
- LOAD: `rotor_load` = 1 for one cycle, then SETTLE. Afterwards return to IDLE; no encryption is launched.
- Key accept:
  - Codes 26–31: pulse `bad_key`, stay in IDLE; no step and no encryption.
  - Codes 0–25: latch into `enc_key`, go to STEP.
- STEP: `rotate` = 1 for ROTATE_HOLD cycles, then SETTLE.
- SETTLE: `rotate` = 0 for SETTLE_CYCLES cycles, then ENC (after a keystroke) or IDLE (after a load).
- ENC: `enc_start` = 1 for one cycle, then WAIT_ENC.
- WAIT_ENC: wait indefinitely for `enc_done`. On `enc_done`, latch `enc_char` into `out_char` and go to OUT.
- OUT: `out_valid` = 1, held until `out_valid` && `out_ready`, then IDLE.
- `enc_done` is ignored outside WAIT_ENC.
- A single shared 4-bit down-counter times STEP and SETTLE. Counter arithmetic is unsigned and reloads on every state entry.

## Timing
- Reset values:
  - Outputs: every output 0, including `rotor_type_*`, `rotor_start_*`, `out_char`, `enc_key`, `cfg_error`.
  - State and counter: state IDLE, counter 0.
- `settings_ready` and `key_ready` are combinational decodes of state == IDLE, so they are 1 in the first cycle after reset is released.
- Key accepted in cycle 0:
  - `rotate` is high in cycles 1..ROTATE_HOLD.
  - `enc_start` is high in cycle 1+ROTATE_HOLD+SETTLE_CYCLES; with defaults that is cycle 6.
- `enc_done` in cycle t gives `out_valid` in cycle t+1.
- Settings accepted in cycle 0: `rotor_load` high in cycle 1, ready again in cycle 2+SETTLE_CYCLES.
- Back-to-back keystrokes: the next key can be accepted in the cycle after the `out_valid` && `out_ready` handshake.
- Reset asserted mid-operation: the next edge returns to IDLE with all outputs at reset values. This includes dropping `rotate` and any pending `out_valid`. The in-flight keystroke is lost.

## Configuration
- `ENIGMA_STEP_COUNT_EN` defined:
  - Adds output `key_count` [15:0].
  - It increments once per `enc_start`, saturates at 16'hFFFF, and clears on reset or on an accepted settings load.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package `enigma_pkg`:
  - `LETTER_W` = 5, `NUM_LETTERS` = 26, `ROTOR_TYPE_W` = 3, `MAX_ROTOR_TYPE` = 4.
  - The state enum type `step_state_t`.
- One sub-module, `step_timer`: loadable 4-bit down-counter with a `zero` flag, used for both the STEP and SETTLE intervals.

## Test plan
- Reset, then load types 0/1/2 with starts 0/0/0: `rotor_load` pulses once in cycle 1, outputs mirror the settings, `settings_ready` returns in cycle 5.
- Key 0 accepted in cycle 0 with defaults: `rotate` high in cycles 1–2, `enc_start` in cycle 6. `enc_done` with `enc_char` = 9 in cycle 10 gives `out_valid`/`out_char` = 9 in cycle 11. Hold `out_ready` low 3 cycles: `out_valid` stays high.
- `key_code` = 27: `bad_key` pulses, no `rotate`, no `enc_start`, `key_ready` stays 1.
- Settings with type 6: `cfg_error` = 1, old configuration unchanged. A following legal load clears `cfg_error`.
- `settings_valid` and `key_valid` together in IDLE: settings take the cycle (`rotor_load` next). The key is accepted only after SETTLE completes.
- Assert `reset_n` = 0 in the second STEP cycle: next cycle `rotate` = 0, IDLE, all outputs reset. With `ENIGMA_STEP_COUNT_EN` defined, `key_count` = 0.

Source files
------------

// File: rtl/enigma_pkg.sv
// Shared types and constants for the Enigma stepping/cipher sequencer.
package enigma_pkg;

  localparam int LETTER_W       = 5;
  localparam int NUM_LETTERS    = 26;
  localparam int ROTOR_TYPE_W   = 3;
  localparam int MAX_ROTOR_TYPE = 4;
  localparam int TIMER_W        = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STEP,
    ST_SETTLE,
    ST_ENC,
    ST_WAIT_ENC,
    ST_OUT
  } step_state_t;

  function automatic logic letter_ok(input logic [LETTER_W-1:0] letter);
    return letter <= LETTER_W'(NUM_LETTERS - 1);
  endfunction

  function automatic logic type_ok(input logic [ROTOR_TYPE_W-1:0] rtype);
    return rtype <= ROTOR_TYPE_W'(MAX_ROTOR_TYPE);
  endfunction

endpackage

// File: rtl/enigma_step_controller_step_timer.sv
// step_timer: loadable down-counter with a terminal-count flag.
// The counter holds at zero until reloaded.
module step_timer #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  // Reload on request, otherwise count down and stop at zero.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  // Terminal count.
  always_comb begin
    zero = (count == '0);
  end

endmodule

// File: rtl/enigma_step_controller.sv
// enigma_step_controller: sequences settings loads and keystrokes into the
// rotor stepping datapath and the cipher path.
// Optional feature macro: ENIGMA_STEP_COUNT_EN adds a saturating key_count.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | ready for settings (priority) or a keystroke
// LOAD      | one-cycle rotor_load pulse with the latched settings
// STEP      | rotate held high for ROTATE_HOLD cycles
// SETTLE    | rotate low for SETTLE_CYCLES while knock carries propagate
// ENC       | one-cycle enc_start
// WAIT_ENC  | wait for enc_done, capture ciphertext
// OUT       | present out_char until out_ready
module enigma_step_controller
  import enigma_pkg::*;
#(
  parameter int ROTATE_HOLD   = 2,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    settings_valid,
  output logic                    settings_ready,
  input  logic [ROTOR_TYPE_W-1:0] set_type_3,
  input  logic [ROTOR_TYPE_W-1:0] set_type_2,
  input  logic [ROTOR_TYPE_W-1:0] set_type_1,
  input  logic [LETTER_W-1:0]     set_start_3,
  input  logic [LETTER_W-1:0]     set_start_2,
  input  logic [LETTER_W-1:0]     set_start_1,
  input  logic                    key_valid,
  output logic                    key_ready,
  input  logic [LETTER_W-1:0]     key_code,
  output logic                    rotate,
  output logic                    rotor_load,
  output logic [ROTOR_TYPE_W-1:0] rotor_type_3,
  output logic [ROTOR_TYPE_W-1:0] rotor_type_2,
  output logic [ROTOR_TYPE_W-1:0] rotor_type_1,
  output logic [LETTER_W-1:0]     rotor_start_3,
  output logic [LETTER_W-1:0]     rotor_start_2,
  output logic [LETTER_W-1:0]     rotor_start_1,
  output logic                    enc_start,
  output logic [LETTER_W-1:0]     enc_key,
  input  logic                    enc_done,
  input  logic [LETTER_W-1:0]     enc_char,
  output logic                    out_valid,
  output logic [LETTER_W-1:0]     out_char,
  input  logic                    out_ready,
`ifdef ENIGMA_STEP_COUNT_EN
  output logic [15:0]             key_count,
`endif
  output logic                    bad_key,
  output logic                    cfg_error
);

  localparam logic [TIMER_W-1:0] HOLD_LD   = TIMER_W'(ROTATE_HOLD - 1);
  localparam logic [TIMER_W-1:0] SETTLE_LD = TIMER_W'(SETTLE_CYCLES - 1);

  step_state_t          state, state_next;
  logic                 after_load;
  logic                 timer_load;
  logic [TIMER_W-1:0]   timer_val;
  logic                 timer_zero;
  logic                 settings_acc;
  logic                 settings_legal;
  logic                 key_acc;

  step_timer #(.W(TIMER_W)) u_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  // Handshake decode and settings legality.
  always_comb begin
    settings_acc   = (state == ST_IDLE) && settings_valid;
    key_acc        = (state == ST_IDLE) && !settings_valid && key_valid;
    settings_legal = type_ok(set_type_3) && type_ok(set_type_2) && type_ok(set_type_1) &&
                     letter_ok(set_start_3) && letter_ok(set_start_2) && letter_ok(set_start_1);
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and timer reload on every state entry.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (settings_acc) begin
          if (settings_legal) state_next = ST_LOAD;
        end else if (key_acc && letter_ok(key_code)) begin
          state_next = ST_STEP;
        end
      end
      ST_LOAD:     state_next = ST_SETTLE;
      ST_STEP:     if (timer_zero) state_next = ST_SETTLE;
      ST_SETTLE:   if (timer_zero) state_next = after_load ? ST_IDLE : ST_ENC;
      ST_ENC:      state_next = ST_WAIT_ENC;
      ST_WAIT_ENC: if (enc_done) state_next = ST_OUT;
      ST_OUT:      if (out_ready) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
    timer_load = (state_next != state);
    case (state_next)
      ST_STEP:   timer_val = HOLD_LD;
      ST_SETTLE: timer_val = SETTLE_LD;
      default:   timer_val = '0;
    endcase
  end

  // Moore outputs decoded from state.
  always_comb begin
    settings_ready = (state == ST_IDLE);
    key_ready      = (state == ST_IDLE) && !settings_valid;
    rotor_load     = (state == ST_LOAD);
    rotate         = (state == ST_STEP);
    enc_start      = (state == ST_ENC);
    out_valid      = (state == ST_OUT);
  end

  // Registered configuration, key/ciphertext capture and error flags.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rotor_type_3  <= '0;
      rotor_type_2  <= '0;
      rotor_type_1  <= '0;
      rotor_start_3 <= '0;
      rotor_start_2 <= '0;
      rotor_start_1 <= '0;
      enc_key       <= '0;
      out_char      <= '0;
      cfg_error     <= 1'b0;
      bad_key       <= 1'b0;
      after_load    <= 1'b0;
    end else begin
      bad_key <= 1'b0;
      if (settings_acc) begin
        if (settings_legal) begin
          rotor_type_3  <= set_type_3;
          rotor_type_2  <= set_type_2;
          rotor_type_1  <= set_type_1;
          rotor_start_3 <= set_start_3;
          rotor_start_2 <= set_start_2;
          rotor_start_1 <= set_start_1;
          cfg_error     <= 1'b0;
          after_load    <= 1'b1;
        end else begin
          cfg_error <= 1'b1;
        end
      end
      if (key_acc) begin
        if (letter_ok(key_code)) begin
          enc_key    <= key_code;
          after_load <= 1'b0;
        end else begin
          bad_key <= 1'b1;
        end
      end
      if ((state == ST_WAIT_ENC) && enc_done) begin
        out_char <= enc_char;
      end
    end
  end

`ifdef ENIGMA_STEP_COUNT_EN
  // Encryption launch counter, saturating, cleared by a new configuration.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      key_count <= '0;
    end else if (settings_acc && settings_legal) begin
      key_count <= '0;
    end else if ((state == ST_ENC) && (key_count != 16'hFFFF)) begin
      key_count <= key_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_enigma_step_controller.sv
// Directed bench for enigma_step_controller; ciphertext results are checked
// through an expected-value queue drained by a separate monitor.
module tb_enigma_step_controller;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       settings_valid, settings_ready;
  logic [2:0] set_type_3, set_type_2, set_type_1;
  logic [4:0] set_start_3, set_start_2, set_start_1;
  logic       key_valid, key_ready;
  logic [4:0] key_code;
  logic       rotate, rotor_load;
  logic [2:0] rotor_type_3, rotor_type_2, rotor_type_1;
  logic [4:0] rotor_start_3, rotor_start_2, rotor_start_1;
  logic       enc_start;
  logic [4:0] enc_key;
  logic       enc_done;
  logic [4:0] enc_char;
  logic       out_valid;
  logic [4:0] out_char;
  logic       out_ready;
  logic       bad_key, cfg_error;
`ifdef ENIGMA_STEP_COUNT_EN
  logic [15:0] key_count;
`endif

  int total = 0;
  int bad   = 0;
  logic [4:0] exp_q[$];

  always #5 clock = ~clock;

  enigma_step_controller dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .settings_valid (settings_valid),
    .settings_ready (settings_ready),
    .set_type_3     (set_type_3),
    .set_type_2     (set_type_2),
    .set_type_1     (set_type_1),
    .set_start_3    (set_start_3),
    .set_start_2    (set_start_2),
    .set_start_1    (set_start_1),
    .key_valid      (key_valid),
    .key_ready      (key_ready),
    .key_code       (key_code),
    .rotate         (rotate),
    .rotor_load     (rotor_load),
    .rotor_type_3   (rotor_type_3),
    .rotor_type_2   (rotor_type_2),
    .rotor_type_1   (rotor_type_1),
    .rotor_start_3  (rotor_start_3),
    .rotor_start_2  (rotor_start_2),
    .rotor_start_1  (rotor_start_1),
    .enc_start      (enc_start),
    .enc_key        (enc_key),
    .enc_done       (enc_done),
    .enc_char       (enc_char),
    .out_valid      (out_valid),
    .out_char       (out_char),
    .out_ready      (out_ready),
`ifdef ENIGMA_STEP_COUNT_EN
    .key_count      (key_count),
`endif
    .bad_key        (bad_key),
    .cfg_error      (cfg_error)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_cfg(input logic [2:0] t3, input logic [2:0] t2, input logic [2:0] t1,
                         input logic [4:0] s3, input logic [4:0] s2, input logic [4:0] s1);
    set_type_3 = t3; set_type_2 = t2; set_type_1 = t1;
    set_start_3 = s3; set_start_2 = s2; set_start_1 = s1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!settings_ready && n < 40) begin
      step();
      n++;
    end
    chk(name, settings_ready, 1);
  endtask

  // Waits for enc_start, answers with ch, and lets the result drain to IDLE.
  task automatic finish_enc(input logic [4:0] key, input logic [4:0] ch);
    int n = 0;
    while (!enc_start && n < 40) begin
      step();
      n++;
    end
    chk("enc_start_seen", enc_start, 1);
    chk("enc_key", enc_key, key);
    step();
    step();
    enc_done = 1'b1;
    enc_char = ch;
    exp_q.push_back(ch);
    out_ready = 1'b1;
    step();
    enc_done = 1'b0;
    chk("out_valid_after_done", out_valid, 1);
    step();
    chk("idle_after_out", key_ready, 1);
    out_ready = 1'b0;
  endtask

  // Monitor: every completed output handshake must match the next expected letter.
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL out_unexpected: got %0d expected none", out_char);
      end else begin
        chk("out_char_sb", out_char, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    reset_n = 1'b0;
    settings_valid = 1'b0;
    key_valid = 1'b0;
    key_code = '0;
    enc_done = 1'b0;
    enc_char = '0;
    out_ready = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0);
    step();
    step();
    chk("rst_rotate", rotate, 0);
    chk("rst_rotor_load", rotor_load, 0);
    chk("rst_enc_start", enc_start, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_char", out_char, 0);
    chk("rst_enc_key", enc_key, 0);
    chk("rst_cfg_error", cfg_error, 0);
    chk("rst_bad_key", bad_key, 0);
    reset_n = 1'b1;
    step();
    chk("rst_settings_ready", settings_ready, 1);
    chk("rst_key_ready", key_ready, 1);

    // Load 0/1/2 at 0/0/0: rotor_load in cycle 1, ready again in cycle 5.
    settings_valid = 1'b1;
    set_cfg(0, 1, 2, 0, 0, 0);
    step();
    settings_valid = 1'b0;
    chk("load_pulse", rotor_load, 1);
    chk("load_type_2", rotor_type_2, 1);
    chk("load_type_1", rotor_type_1, 2);
    chk("load_ready_c1", settings_ready, 0);
    step();
    chk("load_pulse_once", rotor_load, 0);
    step();
    step();
    chk("load_ready_c4", settings_ready, 0);
    step();
    chk("load_ready_c5", settings_ready, 1);

    settings_valid = 1'b1;
    set_cfg(4, 3, 0, 3, 7, 25);
    step();
    settings_valid = 1'b0;
    chk("load2_type_3", rotor_type_3, 4);
    chk("load2_start_3", rotor_start_3, 3);
    chk("load2_start_2", rotor_start_2, 7);
    chk("load2_start_1", rotor_start_1, 25);
    wait_idle("load2_idle");

    // Key 0: rotate cycles 1-2, enc_start cycle 6, enc_done cycle 10.
    key_valid = 1'b1;
    key_code = 5'd0;
    chk("key0_ready_c0", key_ready, 1);
    step();
    key_valid = 1'b0;
    chk("key0_rotate_c1", rotate, 1);
    step();
    chk("key0_rotate_c2", rotate, 1);
    step();
    chk("key0_rotate_c3", rotate, 0);
    step();
    step();
    chk("key0_enc_start_c5", enc_start, 0);
    step();
    chk("key0_enc_start_c6", enc_start, 1);
    step();
    chk("key0_enc_start_c7", enc_start, 0);
    step();
    step();
    step();
    enc_done = 1'b1;
    enc_char = 5'd9;
    exp_q.push_back(5'd9);
    step();
    enc_done = 1'b0;
    chk("key0_out_valid_c11", out_valid, 1);
    chk("key0_out_char", out_char, 9);
    step();
    chk("key0_hold_c12", out_valid, 1);
    step();
    chk("key0_hold_c13", out_valid, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("key0_out_done", out_valid, 0);

    // Back-to-back keystroke right after the output handshake.
    key_valid = 1'b1;
    key_code = 5'd5;
    chk("b2b_key_ready", key_ready, 1);
    step();
    key_valid = 1'b0;
    chk("b2b_rotate", rotate, 1);
    finish_enc(5'd5, 5'd17);

    // Illegal key 27.
    key_valid = 1'b1;
    key_code = 5'd27;
    step();
    key_valid = 1'b0;
    chk("badkey_pulse", bad_key, 1);
    chk("badkey_key_ready", key_ready, 1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      seen = seen | rotate | enc_start | bad_key;
    end
    chk("badkey_no_activity", seen, 0);

    // Rejected settings keep the old configuration; a legal load clears the flag.
    settings_valid = 1'b1;
    set_cfg(6, 1, 1, 2, 2, 2);
    step();
    settings_valid = 1'b0;
    chk("rej_cfg_error", cfg_error, 1);
    chk("rej_no_load", rotor_load, 0);
    chk("rej_type_3_kept", rotor_type_3, 4);
    chk("rej_settings_ready", settings_ready, 1);
    settings_valid = 1'b1;
    set_cfg(1, 1, 1, 2, 2, 2);
    step();
    settings_valid = 1'b0;
    chk("fix_cfg_error", cfg_error, 0);
    chk("fix_load", rotor_load, 1);
    chk("fix_type_3", rotor_type_3, 1);
    wait_idle("fix_idle");
    settings_valid = 1'b1;
    set_cfg(1, 1, 1, 2, 2, 26);
    step();
    settings_valid = 1'b0;
    chk("rej_start_error", cfg_error, 1);
    chk("rej_start_kept", rotor_start_1, 2);

    // Settings and key together: settings win, key waits for SETTLE to end.
    settings_valid = 1'b1;
    set_cfg(2, 0, 3, 10, 11, 12);
    key_valid = 1'b1;
    key_code = 5'd7;
    chk("both_key_ready_c0", key_ready, 0);
    chk("both_settings_ready_c0", settings_ready, 1);
    step();
    settings_valid = 1'b0;
    chk("both_load_c1", rotor_load, 1);
    chk("both_rotate_c1", rotate, 0);
    step();
    step();
    step();
    chk("both_key_ready_c4", key_ready, 0);
    step();
    chk("both_key_ready_c5", key_ready, 1);
    step();
    key_valid = 1'b0;
    chk("both_rotate_c6", rotate, 1);
    finish_enc(5'd7, 5'd3);
`ifdef ENIGMA_STEP_COUNT_EN
    chk("key_count_one", key_count, 1);
`endif

    // Reset in the second STEP cycle, with a sticky error pending.
    settings_valid = 1'b1;
    set_cfg(5, 0, 0, 0, 0, 0);
    step();
    settings_valid = 1'b0;
    chk("pre_rst_cfg_error", cfg_error, 1);
    key_valid = 1'b1;
    key_code = 5'd12;
    step();
    key_valid = 1'b0;
    step();
    chk("mid_rotate_c2", rotate, 1);
    reset_n = 1'b0;
    step();
    chk("mid_rst_rotate", rotate, 0);
    chk("mid_rst_idle", key_ready, 1);
    chk("mid_rst_enc_key", enc_key, 0);
    chk("mid_rst_type_3", rotor_type_3, 0);
    chk("mid_rst_start_3", rotor_start_3, 0);
    chk("mid_rst_cfg_error", cfg_error, 0);
`ifdef ENIGMA_STEP_COUNT_EN
    chk("mid_rst_key_count", key_count, 0);
`endif
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      seen = seen | rotate | enc_start | out_valid;
    end
    chk("mid_rst_key_lost", seen, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
